// File: rtl/apex20ke_bidir_link_ctrl.sv
// apex20ke_bidir_link_ctrl
//   Half-duplex serial link controller for one bidirectional pad driven
//   through an apex20ke_io_bidir atom (pad_out -> datain, pad_oe -> oe,
//   combout -> pad_in). Sends a command frame, releases the pad, waits a
//   turnaround time and optionally receives the remote end's reply frame.
//   Frame: start 0, WIDTH data bits LSB first, [parity], stop 1.
//
// Optional feature macro: APEX20KE_BIDIR_LINK_PARITY_EN
//   Adds an even-parity bit after the data bits in both directions and the
//   rx_parity_err output.
//
// Ports:
//   clk, sclr              clock, synchronous active-high reset
//   tx_valid/tx_ready      host command handshake
//   tx_data                command payload
//   tx_expect_reply        wait for a reply frame after the command
//   rx_valid               one-cycle pulse: reply frame received
//   rx_data                reply payload, held until the next rx_valid
//   rx_frame_err           stop bit sampled low (qualifies rx_valid)
//   rx_parity_err          parity odd (qualifies rx_valid, parity build only)
//   rx_timeout             one-cycle pulse: no reply start bit in time
//   busy                   high in every state except IDLE
//   pad_out, pad_oe        to the I/O atom
//   pad_in                 from the I/O atom, asynchronous
module apex20ke_bidir_link_ctrl #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int TURN_CLKS    = 8,
   parameter int TIMEOUT_CLKS = 1024
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_expect_reply,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_frame_err,
`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
   output logic             rx_parity_err,
`endif
   output logic             rx_timeout,
   output logic             busy,
   output logic             pad_out,
   output logic             pad_oe,
   input  logic             pad_in
);

`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // Serial payload bits per frame (data plus optional parity).
   localparam int SW      = WIDTH + PAR;
   localparam int CNT_MAX = (CLKS_PER_BIT > TURN_CLKS) ? CLKS_PER_BIT : TURN_CLKS;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(TIMEOUT_CLKS + 1);
   localparam int BW      = $clog2(SW + 1);

   typedef enum logic [3:0] {
      IDLE, TX_START, TX_DATA, TX_STOP, TURN,
      RX_WAIT, RX_START, RX_DATA, RX_STOP
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   clk_cnt_reg;
   logic [BW-1:0]   bit_cnt_reg;
   logic [TW-1:0]   tmo_cnt_reg;
   // One spare bit on each shifter: the TX side keeps the stop bit at the
   // top so pad_out can always take bit 1; the RX side lands samples in
   // [SW:1], which stays a legal range even for a 1-bit frame.
   logic [SW:0]     tx_shift_reg;
   logic [SW:0]     rx_shift_reg;
   logic [SW:0]     tx_load;
   logic            expect_reg;
   logic            sync1_reg, sync2_reg, sync3_reg;

   logic bit_end, half_end, turn_end, last_bit, line_fall, tmo_end;

`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
   assign tx_load = {1'b1, ^tx_data, tx_data};
`else
   assign tx_load = {1'b1, tx_data};
`endif

   assign bit_end   = (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));
   assign half_end  = (clk_cnt_reg == CW'(CLKS_PER_BIT / 2 - 1));
   assign turn_end  = (clk_cnt_reg == CW'(TURN_CLKS - 1));
   assign last_bit  = (bit_cnt_reg == BW'(SW - 1));
   // A start needs a genuine 1->0 transition on the synchronized line.
   assign line_fall = sync3_reg & ~sync2_reg;
   assign tmo_end   = (tmo_cnt_reg >= TW'(TIMEOUT_CLKS - 1));
   assign busy      = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_reg     <= IDLE;
         tx_ready      <= 1'b0;
         pad_oe        <= 1'b0;
         pad_out       <= 1'b1;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_frame_err  <= 1'b0;
`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         rx_timeout    <= 1'b0;
         clk_cnt_reg   <= '0;
         bit_cnt_reg   <= '0;
         tmo_cnt_reg   <= '0;
         tx_shift_reg  <= '0;
         rx_shift_reg  <= '0;
         expect_reg    <= 1'b0;
         // Preset to the idle level so reset release cannot fake an edge.
         sync1_reg     <= 1'b1;
         sync2_reg     <= 1'b1;
         sync3_reg     <= 1'b1;
      end else begin
         sync1_reg     <= pad_in;
         sync2_reg     <= sync1_reg;
         sync3_reg     <= sync2_reg;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         rx_timeout    <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  tx_ready     <= 1'b0;
                  tx_shift_reg <= tx_load;
                  expect_reg   <= tx_expect_reply;
                  pad_oe       <= 1'b1;
                  pad_out      <= 1'b0;
                  clk_cnt_reg  <= '0;
                  state_reg    <= TX_START;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  clk_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
                  pad_out     <= tx_shift_reg[0];
                  state_reg   <= TX_DATA;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  clk_cnt_reg  <= '0;
                  pad_out      <= tx_shift_reg[1];
                  tx_shift_reg <= tx_shift_reg >> 1;
                  if (last_bit) state_reg <= TX_STOP;
                  else          bit_cnt_reg <= bit_cnt_reg + BW'(1);
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            TX_STOP: begin
               if (bit_end) begin
                  clk_cnt_reg <= '0;
                  pad_oe      <= 1'b0;
                  pad_out     <= 1'b1;
                  state_reg   <= TURN;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            TURN: begin
               if (turn_end) begin
                  clk_cnt_reg <= '0;
                  tmo_cnt_reg <= '0;
                  state_reg   <= expect_reg ? RX_WAIT : IDLE;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            RX_WAIT: begin
               // The timeout keeps counting through false starts so a noisy
               // line cannot stretch the reply window.
               if (!tmo_end) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
               if (line_fall) begin
                  clk_cnt_reg <= '0;
                  state_reg   <= RX_START;
               end else if (tmo_end) begin
                  rx_timeout <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            RX_START: begin
               if (!tmo_end) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
               if (half_end) begin
                  clk_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
                  state_reg   <= sync2_reg ? RX_WAIT : RX_DATA;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            RX_DATA: begin
               if (bit_end) begin
                  clk_cnt_reg  <= '0;
                  rx_shift_reg <= {sync2_reg, rx_shift_reg[SW:1]};
                  if (last_bit) state_reg <= RX_STOP;
                  else          bit_cnt_reg <= bit_cnt_reg + BW'(1);
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            RX_STOP: begin
               if (bit_end) begin
                  clk_cnt_reg   <= '0;
                  rx_valid      <= 1'b1;
                  rx_data       <= rx_shift_reg[WIDTH:1];
                  rx_frame_err  <= ~sync2_reg;
`ifdef APEX20KE_BIDIR_LINK_PARITY_EN
                  rx_parity_err <= ^rx_shift_reg[SW:1];
`endif
                  state_reg     <= IDLE;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
